dcs_result_packer: RTL
======================

Name: dcs_result_packer

Overview:
- Downstream stage of the DCSformer core. Captures the 8-word, 32-bit result burst from the core's o_valid/o_data outputs.
- Re-quantizes each word to 8 bits and finds the argmax of the raw words.
- Emits three 32-bit beats on a valid/ready interface toward the system bus.
- The core has no backpressure, so this block absorbs the burst unconditionally and buffers it while the bus stalls.

Parameters:
- N_WORDS, 8, words per result burst (fixed at 8; argmax field is 3 bits).
- SHIFT, 8, right-shift applied before 8-bit saturation; legal range 1..24.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  result word valid (from core o_valid).
- in_data  input  32  result word (from core o_data).
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  32  output beat.
- out_last  output  1  high on the final beat (beat 2) of a packet.
- busy  output  1  high while not in COLLECT.
- err  output  1  sticky: an input word arrived while not in COLLECT.

Behaviour:
- Reset: synchronous, active-high; one clk with rst=1 fully clears the block.
  - State returns to COLLECT; word counter = 0; stored words, max and index are cleared.
  - Outputs after reset: out_valid=0, out_data=0, out_last=0, busy=0, err=0.
  - Applies in any state, including mid-EMIT; a partially sent packet is abandoned.
- States: COLLECT, EMIT0, EMIT1, EMIT2.
- COLLECT:
  - Each cycle with in_valid=1 stores q[cnt] and updates the running max/argmax; cnt increments.
  - Gaps in in_valid are tolerated: cnt holds.
  - When the 8th word (cnt=7) is accepted: next cycle is EMIT0, out_valid=1, cnt cleared.
  - Latency from last input word to first out_valid: 1 cycle.
- Quantize: q = min((word >> SHIFT), 255), computed at 33-bit width with no wrap.
  - sat_mask[i] = 1 when word i saturated.
- Argmax:
  - Taken over raw 32-bit words, unsigned compare.
  - Ties resolve to the lowest index; word 0 always initializes max.
  - q_max = q[argmax].
- Beat formats:
  - EMIT0 out_data = {q3,q2,q1,q0}.
  - EMIT1 out_data = {q7,q6,q5,q4}.
  - EMIT2 out_data = {sat_mask[7:0], 13'b0, argmax[2:0], q_max[7:0]}, with out_last=1.
- Handshake:
  - A beat transfers on out_valid & out_ready.
  - out_valid, out_data and out_last are registered and held stable until transfer; out_valid never drops without a transfer.
  - EMITn advances to the next beat on transfer; EMIT2 returns to COLLECT on transfer.
  - Back-to-back packets: COLLECT accepts the new word in the cycle after the EMIT2 transfer.
- Overrun:
  - in_valid=1 in any EMIT state: the word is dropped and err is set; err stays set until rst.
  - The buffered packet is not corrupted.
- out_valid=0 in COLLECT; out_data is don't-care there but must be driven 0.

Optional Feature:
- Macro ROUND_EN.
  - Defined: round-half-up before the shift, q = min(((word + 2^(SHIFT-1)) >> SHIFT), 255), sum at 33 bits. sat_mask reflects the rounded value.
  - Undefined: truncation as above.
  - Argmax always uses raw words in both builds.

Test Plan:
- Words 0x100,0x200,...,0x800, out_ready=1 -> beats 0x04030201, 0x08070605, 0x00000708; out_last only on the third beat; first out_valid 1 cycle after the 8th word.
- Word3=0x00010000, others 0 -> beats 0xFF000000, 0x00000000, 0x080003FF.
- All words 0x500 (tie) -> beats 0x05050505, 0x05050505, 0x00000005; argmax=0.
- out_ready low 5 cycles in EMIT1, plus an in_valid pulse during EMIT1 -> out_valid and out_data held at 0x08070605; err=1 and sticky; the next 8-word packet emits correctly.
- ROUND_EN build: word0=0x180, others 0 -> beat0 low byte 0x02 (0x01 without the macro). word0=0xFFFFFFFF -> low byte 0xFF, sat_mask bit0=1, no wrap.
- rst=1 for one cycle during EMIT1 -> next cycle out_valid=0, busy=0, err=0; a fresh 8-word burst produces a correct packet.

Source files
------------

// File: rtl/dcs_result_packer_if.sv
// Result-bus bundle for dcs_result_packer: core-side word input
// plus the valid/ready beat output toward the system bus.
interface dcs_result_packer_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/dcs_result_packer.sv
// Captures an 8-word result burst, re-quantizes to 8 bits, finds argmax
// and emits three beats. Optional ROUND_EN: round-half-up before shift.
module dcs_result_packer #(
    parameter int N_WORDS = 8,
    parameter int SHIFT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    dcs_result_packer_if.slave bus,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {COLLECT, EMIT0, EMIT1, EMIT2} state_t;

    state_t               state, state_d;
    logic [2:0]           cnt;
    logic [7:0]           q [N_WORDS];
    logic [N_WORDS-1:0]   sat;
    logic [31:0]          max_w;
    logic [2:0]           arg;
    logic                 out_valid_r, out_last_r;
    logic [31:0]          out_data_r, out_data_d;
    logic [32:0]          in_sum, in_shift;
    logic [7:0]           in_q;
    logic                 in_sat;
    logic                 take, last_word, xfer;

    // Quantize the incoming word at 33 bits so the rounding add cannot wrap
    always_comb begin
        in_sum = {1'b0, bus.in_data};
`ifdef ROUND_EN
        in_sum = in_sum + (33'd1 << (SHIFT - 1));
`endif
        in_shift = in_sum >> SHIFT;
        in_sat   = |in_shift[32:8];
        in_q     = in_sat ? 8'hFF : in_shift[7:0];
    end

    assign take      = (state == COLLECT) && bus.in_valid;
    assign last_word = take && (cnt == 3'(N_WORDS - 1));
    assign xfer      = out_valid_r && bus.out_ready;

    // Next state and the beat to present once that state is entered
    always_comb begin
        state_d    = state;
        out_data_d = out_data_r;
        unique case (state)
            COLLECT: begin
                out_data_d = '0;
                if (last_word) begin
                    state_d    = EMIT0;
                    out_data_d = {q[3], q[2], q[1], q[0]};
                end
            end
            EMIT0: if (xfer) begin
                state_d    = EMIT1;
                out_data_d = {q[7], q[6], q[5], q[4]};
            end
            EMIT1: if (xfer) begin
                state_d    = EMIT2;
                out_data_d = {sat[7:0], 13'b0, arg, q[arg]};
            end
            EMIT2: if (xfer) begin
                state_d    = COLLECT;
                out_data_d = '0;
            end
            default: begin
                state_d    = COLLECT;
                out_data_d = '0;
            end
        endcase
    end

    // State register with registered beat outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
        end else begin
            state       <= state_d;
            out_valid_r <= (state_d != COLLECT);
            out_last_r  <= (state_d == EMIT2);
            out_data_r  <= out_data_d;
        end
    end

    // Word capture, running argmax and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            sat   <= '0;
            max_w <= '0;
            arg   <= '0;
            err   <= 1'b0;
            for (int i = 0; i < N_WORDS; i++) q[i] <= '0;
        end else begin
            if (take) begin
                q[cnt]   <= in_q;
                sat[cnt] <= in_sat;
                if (cnt == 3'd0 || bus.in_data > max_w) begin
                    max_w <= bus.in_data;
                    arg   <= cnt;
                end
                cnt <= last_word ? 3'd0 : cnt + 3'd1;
            end
            if (bus.in_valid && state != COLLECT) err <= 1'b1;
        end
    end

    assign busy          = (state != COLLECT);
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_data  = out_data_r;
endmodule
